// File: rtl/multdiv_arbiter_if.sv
// multdiv_arbiter_if
//   Bundle of every signal between the multiply/divide arbiter, its two
//   requesters and the shared multi-cycle unit.
//   slave  : arbiter side (drives ready/done/rsp_*, md_ctrl_*, md_a/md_b,
//            busy, timeout_err; receives requests and unit results)
//   master : environment side (requesters plus the unit), the mirror image
interface multdiv_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid, req0_op, req0_ready, req0_done;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_op, req1_ready, req1_done;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_exception;
    logic             md_ctrl_mult, md_ctrl_div;
    logic [WIDTH-1:0] md_a, md_b;
    logic [WIDTH-1:0] md_result;
    logic             md_exception, md_resultRDY;
    logic             busy, timeout_err;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req0_done, req1_ready, req1_done,
        output rsp_result, rsp_exception,
        output md_ctrl_mult, md_ctrl_div, md_a, md_b,
        input  md_result, md_exception, md_resultRDY,
        output busy, timeout_err
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req0_done, req1_ready, req1_done,
        input  rsp_result, rsp_exception,
        input  md_ctrl_mult, md_ctrl_div, md_a, md_b,
        output md_result, md_exception, md_resultRDY,
        input  busy, timeout_err
    );
endinterface

// File: rtl/multdiv_arbiter.sv
// multdiv_arbiter
//   Round-robin arbiter and sequencer for one shared multi-cycle
//   multiply/divide unit serving two requesters (port 0 = pipeline,
//   port 1 = game-logic engine). Flow per operation:
//   IDLE (grant) -> ISSUE (start pulse) -> WAIT (watchdog) -> RESP (done).
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : multdiv_arbiter_if.slave (requests, responses, unit control)
// Optional build macro:
//   MDARB_DIVZERO_FAST_EN - a divide by zero never reaches the unit; it is
//   answered with result 0 / exception 1, two cycles after the grant.
module multdiv_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40,   // must exceed the unit latency
    parameter int CNT_W   = 6     // 2**CNT_W > TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    multdiv_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic             ptr;      // port preferred when both request
    logic             owner;    // port that issued the current op
    logic [CNT_W-1:0] wd;
    logic             grant0, grant1, win_op;
    logic [WIDTH-1:0] win_a, win_b;
`ifdef MDARB_DIVZERO_FAST_EN
    logic             fast;     // current op is a short-circuited divide by zero
`endif

    // Grants are combinational so the requester sees ready in the same cycle.
    assign grant0 = reset && (state == IDLE) && bus.req0_valid && (!bus.req1_valid || !ptr);
    assign grant1 = reset && (state == IDLE) && bus.req1_valid && (!bus.req0_valid ||  ptr);
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    assign win_op = grant1 ? bus.req1_op : bus.req0_op;
    assign win_a  = grant1 ? bus.req1_a  : bus.req0_a;
    assign win_b  = grant1 ? bus.req1_b  : bus.req0_b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            ptr               <= 1'b0;
            owner             <= 1'b0;
            wd                <= '0;
            bus.md_ctrl_mult  <= 1'b0;
            bus.md_ctrl_div   <= 1'b0;
            bus.md_a          <= '0;
            bus.md_b          <= '0;
            bus.req0_done     <= 1'b0;
            bus.req1_done     <= 1'b0;
            bus.rsp_result    <= '0;
            bus.rsp_exception <= 1'b0;
            bus.busy          <= 1'b0;
            bus.timeout_err   <= 1'b0;
`ifdef MDARB_DIVZERO_FAST_EN
            fast              <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless set below.
            bus.md_ctrl_mult <= 1'b0;
            bus.md_ctrl_div  <= 1'b0;
            bus.req0_done    <= 1'b0;
            bus.req1_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        bus.md_a <= win_a;
                        bus.md_b <= win_b;
                        owner    <= grant1;
                        ptr      <= ~grant1;
                        bus.busy <= 1'b1;
                        state    <= ISSUE;
`ifdef MDARB_DIVZERO_FAST_EN
                        fast <= win_op && (win_b == '0);
                        if (!(win_op && (win_b == '0))) begin
                            bus.md_ctrl_mult <= ~win_op;
                            bus.md_ctrl_div  <=  win_op;
                        end
`else
                        bus.md_ctrl_mult <= ~win_op;
                        bus.md_ctrl_div  <=  win_op;
`endif
                    end
                end
                ISSUE: begin
                    wd    <= '0;
                    state <= WAIT;
`ifdef MDARB_DIVZERO_FAST_EN
                    // Short-circuit: the ISSUE cycle passes without a start
                    // pulse so grant-to-done stays at 2 cycles.
                    if (fast) begin
                        bus.rsp_result    <= '0;
                        bus.rsp_exception <= 1'b1;
                        bus.req0_done     <= ~owner;
                        bus.req1_done     <=  owner;
                        state             <= RESP;
                    end
`endif
                end
                WAIT: begin
                    // A result arriving on the last watchdog cycle still wins.
                    if (bus.md_resultRDY) begin
                        bus.rsp_result    <= bus.md_result;
                        bus.rsp_exception <= bus.md_exception;
                        bus.req0_done     <= ~owner;
                        bus.req1_done     <=  owner;
                        state             <= RESP;
                    end else if (wd == CNT_W'(TIMEOUT - 1)) begin
                        bus.rsp_result    <= '0;
                        bus.rsp_exception <= 1'b1;
                        bus.timeout_err   <= 1'b1;
                        bus.req0_done     <= ~owner;
                        bus.req1_done     <=  owner;
                        state             <= RESP;
                    end else begin
                        wd <= wd + CNT_W'(1);
                    end
                end
                RESP: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_arbiter.sv
// tb_multdiv_arbiter
//   Directed bench for multdiv_arbiter. The bench plays both requesters and
//   the multiply/divide unit; every expected value is hand-computed.
//   Inputs change 1 time unit after the rising edge, outputs are checked
//   1-2 units after the edge.
module tb_multdiv_arbiter;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 40;

    logic clock = 1'b0;
    logic reset = 1'b0;

    multdiv_arbiter_if #(.WIDTH(WIDTH)) bus ();

    multdiv_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;
    // Event counters sampled mid-cycle; the main sequence compares deltas.
    int n_mult = 0, n_div = 0, n_done0 = 0, n_done1 = 0;

    always @(negedge clock) begin
        if (bus.md_ctrl_mult) n_mult++;
        if (bus.md_ctrl_div)  n_div++;
        if (bus.req0_done)    n_done0++;
        if (bus.req1_done)    n_done1++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int b_mult, b_div, b_d0, b_d1;
        bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.md_result = 0; bus.md_exception = 0; bus.md_resultRDY = 0;

        // ---- reset state ------------------------------------------------
        step(3);
        bus.req0_valid = 1;
        #1;
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_timeout_err", bus.timeout_err, 0);
        check("rst_md_a", bus.md_a, 0);
        check("rst_rsp_result", bus.rsp_result, 0);
        check("rst_ctrl", {bus.md_ctrl_mult, bus.md_ctrl_div}, 0);
        bus.req0_valid = 0;
        reset = 1;
        step(1);

        // ---- T1: port 0 mult 7 x 6, unit latency 17 --------------------
        b_mult = n_mult;
        bus.req0_valid = 1; bus.req0_op = 0; bus.req0_a = 7; bus.req0_b = 6;
        #1;
        check("t1_ready0", bus.req0_ready, 1);
        check("t1_ready1", bus.req1_ready, 0);
        step(1);                                   // g+1 ISSUE
        bus.req0_valid = 0;
        bus.md_resultRDY = 1; bus.md_result = 99;  // must be ignored in ISSUE
        check("t1_ctrl_mult", bus.md_ctrl_mult, 1);
        check("t1_ctrl_div", bus.md_ctrl_div, 0);
        check("t1_md_a", bus.md_a, 7);
        check("t1_md_b", bus.md_b, 6);
        check("t1_busy", bus.busy, 1);
        step(1);                                   // g+2
        bus.md_resultRDY = 0;
        check("t1_no_early_done", bus.req0_done, 0);
        step(16);                                  // g+18
        bus.md_resultRDY = 1; bus.md_result = 42; bus.md_exception = 0;
        step(1);                                   // g+19 RESP
        bus.md_resultRDY = 0; bus.md_result = 32'hdead;
        check("t1_done0", bus.req0_done, 1);
        check("t1_done1", bus.req1_done, 0);
        check("t1_result", bus.rsp_result, 42);
        check("t1_exc", bus.rsp_exception, 0);
        check("t1_mult_pulses", n_mult - b_mult, 1);
        step(1);
        check("t1_done0_clear", bus.req0_done, 0);
        check("t1_idle_busy", bus.busy, 0);
        check("t1_result_hold", bus.rsp_result, 42);

        // ---- T2: simultaneous requests, pointer back at port 0 ---------
        reset = 0;
        step(1);
        reset = 1;
        bus.req0_valid = 1; bus.req0_op = 0; bus.req0_a = 3;   bus.req0_b = 5;
        bus.req1_valid = 1; bus.req1_op = 1; bus.req1_a = 100; bus.req1_b = 7;
        #1;
        check("t2_ready0", bus.req0_ready, 1);
        check("t2_ready1", bus.req1_ready, 0);
        step(1);                                   // g+1 ISSUE
        check("t2_busy_ready1", bus.req1_ready, 0);
        check("t2_md_a", bus.md_a, 3);
        step(2);                                   // g+3
        bus.md_resultRDY = 1; bus.md_result = 15;
        step(1);                                   // g+4 RESP
        bus.md_resultRDY = 0;
        bus.req0_a = 9; bus.req0_b = 9;            // port 0 re-requests
        check("t2_done0", bus.req0_done, 1);
        check("t2_result", bus.rsp_result, 15);
        check("t2_resp_ready1", bus.req1_ready, 0);
        step(1);                                   // IDLE, both valid
        #1;
        check("t2_rr_ready1", bus.req1_ready, 1);
        check("t2_rr_ready0", bus.req0_ready, 0);

        // ---- T3: port 1 div 100 / 7, unit latency 32 -------------------
        b_div = n_div; b_d0 = n_done0;
        step(1);                                   // h+1 ISSUE
        bus.req1_valid = 0;
        check("t3_ctrl_div", bus.md_ctrl_div, 1);
        check("t3_ctrl_mult", bus.md_ctrl_mult, 0);
        check("t3_ready0_busy", bus.req0_ready, 0);
        step(16);                                  // h+17
        check("t3_md_a_hold", bus.md_a, 100);
        check("t3_md_b_hold", bus.md_b, 7);
        step(16);                                  // h+33
        bus.md_resultRDY = 1; bus.md_result = 14; bus.md_exception = 0;
        step(1);                                   // h+34 RESP
        bus.md_resultRDY = 0;
        check("t3_done1", bus.req1_done, 1);
        check("t3_done0", bus.req0_done, 0);
        check("t3_result", bus.rsp_result, 14);
        check("t3_no_done0", n_done0 - b_d0, 0);
        check("t3_div_pulses", n_div - b_div, 1);

        // ---- T4: port 0 mult, unit never answers -> watchdog -----------
        step(1);                                   // k IDLE
        #1;
        check("t4_ready0", bus.req0_ready, 1);
        step(1);                                   // k+1 ISSUE
        bus.req0_valid = 0;
        check("t4_terr_before", bus.timeout_err, 0);
        step(40);                                  // k+41
        check("t4_not_yet", bus.req0_done, 0);
        step(1);                                   // k+42 RESP
        check("t4_done0", bus.req0_done, 1);
        check("t4_result", bus.rsp_result, 0);
        check("t4_exc", bus.rsp_exception, 1);
        check("t4_terr", bus.timeout_err, 1);
        step(1);
        check("t4_terr_sticky", bus.timeout_err, 1);
        check("t4_idle", bus.busy, 0);

        // ---- T5: reset during WAIT ---------------------------------------
        bus.req1_valid = 1; bus.req1_op = 0; bus.req1_a = 2; bus.req1_b = 3;
        #1;
        check("t5_ready1", bus.req1_ready, 1);
        step(1);
        bus.req1_valid = 0;
        step(5);
        b_d0 = n_done0; b_d1 = n_done1;
        #1;
        reset = 0;
        #1;
        check("t5_busy_async", bus.busy, 0);
        check("t5_terr_cleared", bus.timeout_err, 0);
        check("t5_md_a_cleared", bus.md_a, 0);
        step(2);
        reset = 1;
        check("t5_no_done", (n_done0 - b_d0) + (n_done1 - b_d1), 0);

        // ---- T6: divide by zero on port 0 --------------------------------
        b_div = n_div;
        bus.req0_valid = 1; bus.req0_op = 1; bus.req0_a = 5; bus.req0_b = 0;
        #1;
        check("t6_ready0", bus.req0_ready, 1);
        step(1);                                   // g+1
        bus.req0_valid = 0;
`ifdef MDARB_DIVZERO_FAST_EN
        check("t6_no_ctrl_div", bus.md_ctrl_div, 0);
        step(1);                                   // g+2 RESP
        check("t6_done0", bus.req0_done, 1);
        check("t6_result", bus.rsp_result, 0);
        check("t6_exc", bus.rsp_exception, 1);
        check("t6_terr", bus.timeout_err, 0);
        check("t6_div_pulses", n_div - b_div, 0);
`else
        check("t6_ctrl_div", bus.md_ctrl_div, 1);
        check("t6_md_b", bus.md_b, 0);
        step(3);                                   // g+4
        bus.md_resultRDY = 1; bus.md_result = 32'hffff_ffff; bus.md_exception = 1;
        step(1);                                   // g+5 RESP
        bus.md_resultRDY = 0; bus.md_exception = 0;
        check("t6_done0", bus.req0_done, 1);
        check("t6_result", bus.rsp_result, 32'hffff_ffff);
        check("t6_exc", bus.rsp_exception, 1);
        check("t6_div_pulses", n_div - b_div, 1);
`endif
        step(1);
        check("t6_idle", bus.busy, 0);
        check("t6_done_clear", bus.req0_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/multdiv_arbiter.md
Name: multdiv_arbiter

Overview:
Controller and two-requester arbiter for the shared multi-cycle multiply/divide unit. It accepts operations from the pipeline (port 0) and the game-logic engine (port 1) and grants them round-robin. It latches the operands, pulses the unit's start control, then waits for the unit's result-ready flag, with a watchdog timeout. It returns the result and exception flag to the requester that issued the operation.

Parameters:
WIDTH, 32, operand/result width
TIMEOUT, 40, max cycles in WAIT before forced abort (must exceed unit latency of 32)
CNT_W, 6, watchdog counter width (2^CNT_W > TIMEOUT)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
req0_valid  in  1  port 0 request
req0_op  in  1  0 = multiply, 1 = divide
req0_a, req0_b  in  WIDTH  port 0 operands
req0_ready  out  1  port 0 request accepted this cycle
req0_done  out  1  one-cycle result strobe for port 0
req1_valid, req1_op, req1_a, req1_b, req1_ready, req1_done  -  same as port 0, for port 1
rsp_result  out  WIDTH  result, valid while a reqN_done is high
rsp_exception  out  1  exception, valid while a reqN_done is high
md_ctrl_mult  out  1  one-cycle start pulse to unit, multiply
md_ctrl_div  out  1  one-cycle start pulse to unit, divide
md_a, md_b  out  WIDTH  latched operands to unit
md_result  in  WIDTH  unit result
md_exception  in  1  unit exception
md_resultRDY  in  1  unit result ready
busy  out  1  high in any state except IDLE
timeout_err  out  1  sticky; set on watchdog abort, cleared only by reset

Behaviour:
- Reset (reset = 0, asynchronous) values:
  - state = IDLE; priority pointer = port 0; watchdog = 0.
  - All outputs 0: ready/done strobes, md_ctrl_*, md_a/md_b, rsp_*, busy, timeout_err.
- IDLE:
  - Arbitrates when any reqN_valid is high.
  - If both are valid, the port named by the priority pointer wins.
  - Winner's reqN_ready is pulsed combinationally the same cycle.
  - On the clock edge: latch op and operands into md_a/md_b, record the owner, go to ISSUE.
  - The pointer flips to the other port after each grant.
- ISSUE (1 cycle):
  - Assert exactly one of md_ctrl_mult/md_ctrl_div for this one cycle.
  - Clear the watchdog, go to WAIT.
- WAIT:
  - md_a/md_b are held stable; the watchdog increments each cycle.
  - md_resultRDY = 1: capture md_result/md_exception into rsp_*, go to RESP. md_resultRDY is ignored in IDLE and ISSUE.
  - Watchdog reaches TIMEOUT without md_resultRDY: rsp_result = 0, rsp_exception = 1, set timeout_err, go to RESP.
  - If md_resultRDY and timeout occur in the same cycle, md_resultRDY wins.
- RESP (1 cycle):
  - Assert the owner's reqN_done. Exactly one done is high, never both.
  - Return to IDLE. The next grant can occur in the IDLE cycle that follows, so at most one op per 3 + unit-latency cycles.
- Latency: grant to done = 2 + unit latency cycles (unit latency counts ISSUE to md_resultRDY).
- Requesters hold valid/op/operands until ready is seen. Dropping valid before the grant withdraws the request with no side effect.
- rsp_result/rsp_exception hold their last value outside RESP.
- Reset asserted mid-operation: immediate return to IDLE; the pending op is discarded and no done is issued.
- The arbiter never overlaps two operations on the unit.

Optional Feature:
Macro MDARB_DIVZERO_FAST_EN.
- Defined: a granted divide with b == 0 skips ISSUE/WAIT.
  - No md_ctrl_* pulse is generated.
  - Next state is RESP with rsp_result = 0, rsp_exception = 1.
  - Grant to done = 2 cycles; timeout_err is unaffected.
- Not defined: divide-by-zero is sent to the unit like any op, and its exception is passed through.

Test Plan:
- Port 0 mult 7 x 6, unit RDY 17 cycles after pulse -> one md_ctrl_mult pulse; req0_done with rsp_result = 42, rsp_exception = 0, 19 cycles after grant.
- Both ports valid in the same cycle after reset -> port 0 granted first; port 1 granted in the IDLE cycle after port 0's done; next simultaneous request grants port 1 first.
- Port 1 div 100 / 7, unit RDY after 32 cycles -> req1_done, rsp_result = 14, req0_done stays 0 throughout.
- Unit never asserts RDY -> done TIMEOUT + 2 cycles after grant with rsp_result = 0, rsp_exception = 1, timeout_err = 1 until reset.
- Reset pulled low during WAIT -> busy = 0 immediately, no done strobe; a fresh request afterwards completes normally.
- Div 5 / 0 with MDARB_DIVZERO_FAST_EN -> no md_ctrl_div, done 2 cycles after grant, exception = 1. Without the macro -> md_ctrl_div pulsed, unit exception propagated.
